// File: rtl/sync_fifo_param.sv
// ----------------------------------------------------------------------------
// sync_fifo_param
//
// Single-clock parametrised FIFO for the AXI4-Lite to SDRAM datapath where the
// AXI side and the SDRAM controller share one clock. Power-of-two depth, exact
// occupancy count, programmable almost-full/almost-empty flags, sticky
// overflow/underflow flags and a choice of standard registered read or
// first-word-fall-through (FWFT) read.
//
// Parameters:
//   DATA_WIDTH    width of each stored word
//   ADDR_WIDTH    log2 of the depth (DEPTH = 2**ADDR_WIDTH)
//   AFULL_THRESH  almost_full when count >= AFULL_THRESH
//   AEMPTY_THRESH almost_empty when count <= AEMPTY_THRESH
//   FWFT          0 = registered read with 1-cycle latency, 1 = fall-through
//
// Ports:
//   clk           rising-edge clock for all logic
//   reset         asynchronous active-high reset
//   wr_en         write request, data_in is stored when not full
//   data_in       write data
//   rd_en         read request (standard) or pop of the head word (FWFT)
//   clear_err     synchronous clear of overflow and underflow
//   data_out      read data
//   data_valid    data_out holds a valid word
//   fifo_full     count == DEPTH
//   fifo_empty    count == 0
//   almost_full   count >= AFULL_THRESH
//   almost_empty  count <= AEMPTY_THRESH
//   count         number of stored words, 0..DEPTH
//   overflow      sticky: write attempted while full
//   underflow     sticky: read attempted while empty
// ----------------------------------------------------------------------------
module sync_fifo_param #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDR_WIDTH    = 6,
   parameter int AFULL_THRESH  = 60,
   parameter int AEMPTY_THRESH = 4,
   parameter int FWFT          = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  rd_en,
   input  logic                  clear_err,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_valid,
   output logic                  fifo_full,
   output logic                  fifo_empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int CW    = ADDR_WIDTH + 1;
   localparam int DEPTH = 1 << ADDR_WIDTH;

   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
   localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [CW-1:0]         wr_ptr;
   logic [CW-1:0]         rd_ptr;
   logic [CW-1:0]         count_next;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic                  wr_accept;
   logic                  rd_accept;

   // Accept decisions use the registered (pre-edge) flags only, so a
   // simultaneous read on a full FIFO never makes room for the write in the
   // same cycle, and a write into an empty FIFO never feeds the read.
   always_comb begin
      wr_accept  = wr_en & ~fifo_full;
      rd_accept  = rd_en & ~fifo_empty;
      count_next = count + CW'(wr_accept) - CW'(rd_accept);
      wr_addr    = wr_ptr[ADDR_WIDTH-1:0];
      rd_addr    = rd_ptr[ADDR_WIDTH-1:0];
   end

   // Storage array; deliberately has no reset so it maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (wr_accept) begin
         mem[wr_addr] <= data_in;
      end
   end

   // Pointers, occupancy and every status flag. Flags are computed from the
   // next-state count so they always agree with count in the same cycle.
   // The pointer MSB is a wrap bit; pointers simply roll over at 2*DEPTH.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         fifo_full    <= 1'b0;
         fifo_empty   <= 1'b1;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         if (wr_accept) begin
            wr_ptr <= wr_ptr + CW'(1);
         end
         if (rd_accept) begin
            rd_ptr <= rd_ptr + CW'(1);
         end
         count        <= count_next;
         fifo_full    <= (count_next == DEPTH_C);
         fifo_empty   <= (count_next == '0);
         almost_full  <= (count_next >= AFULL_C);
         almost_empty <= (count_next <= AEMPTY_C);
         if (wr_en && fifo_full) begin
            overflow <= 1'b1;
         end else if (clear_err) begin
            overflow <= 1'b0;
         end
         if (rd_en && fifo_empty) begin
            underflow <= 1'b1;
         end else if (clear_err) begin
            underflow <= 1'b0;
         end
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         // Fall-through: the head word is always on data_out. It is forced to
         // zero while empty so the output is defined (and zero) out of reset.
         assign data_out   = fifo_empty ? '0 : mem[rd_addr];
         assign data_valid = ~fifo_empty;
      end else begin : g_std
         // Registered read: an accepted read loads the head word, and
         // data_valid marks exactly the cycle after that read.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               data_out   <= '0;
               data_valid <= 1'b0;
            end else begin
               data_valid <= rd_accept;
               if (rd_accept) begin
                  data_out <= mem[rd_addr];
               end
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// ----------------------------------------------------------------------------
// tb_sync_fifo_param
//
// Directed self-checking bench for sync_fifo_param. One instance runs in
// standard read mode, a second instance in FWFT mode; both share clock and
// reset. Inputs change 1 time unit after a rising edge, and outputs are
// sampled at that same point, i.e. they reflect the edge just taken.
// ----------------------------------------------------------------------------
module tb_sync_fifo_param;

   logic        clk;
   logic        reset;

   logic        wr_en;
   logic [31:0] data_in;
   logic        rd_en;
   logic        clear_err;
   logic [31:0] data_out;
   logic        data_valid;
   logic        fifo_full;
   logic        fifo_empty;
   logic        almost_full;
   logic        almost_empty;
   logic [6:0]  count;
   logic        overflow;
   logic        underflow;

   logic        f_wr_en;
   logic [31:0] f_data_in;
   logic        f_rd_en;
   logic        f_clear_err;
   logic [31:0] f_data_out;
   logic        f_data_valid;
   logic        f_fifo_full;
   logic        f_fifo_empty;
   logic        f_almost_full;
   logic        f_almost_empty;
   logic [6:0]  f_count;
   logic        f_overflow;
   logic        f_underflow;

   int pass_cnt;
   int total_cnt;

   sync_fifo_param #(
      .DATA_WIDTH(32), .ADDR_WIDTH(6), .AFULL_THRESH(60), .AEMPTY_THRESH(4), .FWFT(0)
   ) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
      .clear_err(clear_err), .data_out(data_out), .data_valid(data_valid),
      .fifo_full(fifo_full), .fifo_empty(fifo_empty), .almost_full(almost_full),
      .almost_empty(almost_empty), .count(count), .overflow(overflow),
      .underflow(underflow)
   );

   sync_fifo_param #(
      .DATA_WIDTH(32), .ADDR_WIDTH(6), .AFULL_THRESH(60), .AEMPTY_THRESH(4), .FWFT(1)
   ) dut_fwft (
      .clk(clk), .reset(reset), .wr_en(f_wr_en), .data_in(f_data_in), .rd_en(f_rd_en),
      .clear_err(f_clear_err), .data_out(f_data_out), .data_valid(f_data_valid),
      .fifo_full(f_fifo_full), .fifo_empty(f_fifo_empty), .almost_full(f_almost_full),
      .almost_empty(f_almost_empty), .count(f_count), .overflow(f_overflow),
      .underflow(f_underflow)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reset values of every output on the standard-mode instance.
   task automatic test_reset();
      logic [13:0] got;
      logic [13:0] exp;
      got = {fifo_empty, almost_empty, fifo_full, almost_full, overflow, underflow,
             data_valid, count};
      exp = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0};
      total_cnt++;
      if (got !== exp) $display("[TB] FAIL reset_flags: got %b expected %b", got, exp);
      else pass_cnt++;
      total_cnt++;
      if (data_out !== 32'h0) $display("[TB] FAIL reset_data_out: got %h expected 0", data_out);
      else pass_cnt++;
   endtask

   // Three writes then three reads with 1-cycle read latency.
   task automatic test_basic();
      logic [31:0] words [3];
      words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;
      for (int i = 0; i < 3; i++) begin
         wr_en = 1'b1; data_in = words[i];
         step();
         total_cnt++;
         if (count !== 7'(i + 1)) $display("[TB] FAIL basic_wr_count: got %0d expected %0d", count, i + 1);
         else pass_cnt++;
      end
      wr_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rd_en = 1'b1;
         step();
         total_cnt++;
         if (data_out !== words[i] || data_valid !== 1'b1 || count !== 7'(2 - i))
            $display("[TB] FAIL basic_rd: got data %h valid %b count %0d expected %h 1 %0d",
                     data_out, data_valid, count, words[i], 2 - i);
         else pass_cnt++;
      end
      rd_en = 1'b0;
      step();
      total_cnt++;
      if (data_valid !== 1'b0 || fifo_empty !== 1'b1 || data_out !== 32'h33)
         $display("[TB] FAIL basic_idle: got valid %b empty %b data %h expected 0 1 33",
                  data_valid, fifo_empty, data_out);
      else pass_cnt++;
   endtask

   // Fill to 64, almost_full at 60, overflow on 65th write, clear_err.
   task automatic test_full();
      for (int i = 0; i < 64; i++) begin
         wr_en = 1'b1; data_in = 32'(i);
         step();
         total_cnt++;
         if (count !== 7'(i + 1) || almost_full !== (i + 1 >= 60))
            $display("[TB] FAIL full_fill: got count %0d afull %b expected %0d %b",
                     count, almost_full, i + 1, (i + 1 >= 60));
         else pass_cnt++;
      end
      total_cnt++;
      if (fifo_full !== 1'b1 || overflow !== 1'b0)
         $display("[TB] FAIL full_flag: got full %b ovf %b expected 1 0", fifo_full, overflow);
      else pass_cnt++;
      data_in = 32'hDEAD;
      step();
      total_cnt++;
      if (overflow !== 1'b1 || count !== 7'd64)
         $display("[TB] FAIL full_overflow: got ovf %b count %0d expected 1 64", overflow, count);
      else pass_cnt++;
      wr_en = 1'b0; clear_err = 1'b1;
      step();
      clear_err = 1'b0;
      total_cnt++;
      if (overflow !== 1'b0 || fifo_full !== 1'b1)
         $display("[TB] FAIL full_clear: got ovf %b full %b expected 0 1", overflow, fifo_full);
      else pass_cnt++;
   endtask

   // Simultaneous read/write on a full FIFO, then drain and check order.
   task automatic test_back_to_back();
      logic [31:0] exp_word;
      rd_en = 1'b1; wr_en = 1'b1; data_in = 32'hBB;
      step();
      total_cnt++;
      if (data_out !== 32'd0 || count !== 7'd63 || overflow !== 1'b1 || data_valid !== 1'b1)
         $display("[TB] FAIL b2b_full_rw: got data %h count %0d ovf %b valid %b expected 0 63 1 1",
                  data_out, count, overflow, data_valid);
      else pass_cnt++;
      data_in = 32'hAA;
      step();
      total_cnt++;
      if (data_out !== 32'd1 || count !== 7'd63 || fifo_full !== 1'b0)
         $display("[TB] FAIL b2b_rw: got data %h count %0d full %b expected 1 63 0",
                  data_out, count, fifo_full);
      else pass_cnt++;
      wr_en = 1'b0;
      for (int i = 0; i < 63; i++) begin
         exp_word = (i < 62) ? 32'(i + 2) : 32'hAA;
         step();
         total_cnt++;
         if (data_out !== exp_word || count !== 7'(62 - i) || almost_empty !== (62 - i <= 4))
            $display("[TB] FAIL b2b_drain: got data %h count %0d aempty %b expected %h %0d %b",
                     data_out, count, almost_empty, exp_word, 62 - i, (62 - i <= 4));
         else pass_cnt++;
      end
      rd_en = 1'b0; clear_err = 1'b1;
      step();
      clear_err = 1'b0;
      total_cnt++;
      if (fifo_empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0)
         $display("[TB] FAIL b2b_end: got empty %b ovf %b udf %b expected 1 0 0",
                  fifo_empty, overflow, underflow);
      else pass_cnt++;
   endtask

   // Random traffic kept strictly between empty and full, against a queue.
   task automatic test_wrap();
      logic [31:0] q[$];
      logic [31:0] exp_word;
      logic        do_wr;
      logic        do_rd;
      for (int i = 0; i < 8; i++) begin
         wr_en = 1'b1; data_in = 32'h1000 + 32'(i);
         q.push_back(data_in);
         step();
      end
      for (int cyc = 0; cyc < 200; cyc++) begin
         do_wr = 1'($urandom_range(0, 1));
         do_rd = 1'($urandom_range(0, 1));
         if (q.size() <= 1) do_rd = 1'b0;
         if (q.size() >= 63) do_wr = 1'b0;
         wr_en = do_wr; rd_en = do_rd; data_in = $urandom;
         exp_word = 32'h0;
         if (do_rd) exp_word = q.pop_front();
         if (do_wr) q.push_back(data_in);
         step();
         total_cnt++;
         if (count !== 7'(q.size()) || data_valid !== do_rd || (do_rd && data_out !== exp_word))
            $display("[TB] FAIL wrap_cycle%0d: got count %0d valid %b data %h expected %0d %b %h",
                     cyc, count, data_valid, data_out, q.size(), do_rd, exp_word);
         else pass_cnt++;
      end
      wr_en = 1'b0; rd_en = 1'b1;
      while (q.size() > 0) begin
         exp_word = q.pop_front();
         step();
         total_cnt++;
         if (data_out !== exp_word || count !== 7'(q.size()))
            $display("[TB] FAIL wrap_drain: got data %h count %0d expected %h %0d",
                     data_out, count, exp_word, q.size());
         else pass_cnt++;
      end
      rd_en = 1'b0;
      step();
      total_cnt++;
      if (fifo_empty !== 1'b1 || underflow !== 1'b0)
         $display("[TB] FAIL wrap_end: got empty %b udf %b expected 1 0", fifo_empty, underflow);
      else pass_cnt++;
   endtask

   // First-word-fall-through presentation, pop, and underflow.
   task automatic test_fwft();
      total_cnt++;
      if (f_data_valid !== 1'b0 || f_fifo_empty !== 1'b1 || f_data_out !== 32'h0)
         $display("[TB] FAIL fwft_idle: got valid %b empty %b data %h expected 0 1 0",
                  f_data_valid, f_fifo_empty, f_data_out);
      else pass_cnt++;
      f_wr_en = 1'b1; f_data_in = 32'h5A;
      step();
      f_wr_en = 1'b0;
      total_cnt++;
      if (f_data_valid !== 1'b1 || f_data_out !== 32'h5A || f_count !== 7'd1)
         $display("[TB] FAIL fwft_present: got valid %b data %h count %0d expected 1 5a 1",
                  f_data_valid, f_data_out, f_count);
      else pass_cnt++;
      f_rd_en = 1'b1;
      step();
      total_cnt++;
      if (f_data_valid !== 1'b0 || f_fifo_empty !== 1'b1 || f_underflow !== 1'b0)
         $display("[TB] FAIL fwft_pop: got valid %b empty %b udf %b expected 0 1 0",
                  f_data_valid, f_fifo_empty, f_underflow);
      else pass_cnt++;
      step();
      f_rd_en = 1'b0;
      total_cnt++;
      if (f_underflow !== 1'b1 || f_count !== 7'd0)
         $display("[TB] FAIL fwft_underflow: got udf %b count %0d expected 1 0", f_underflow, f_count);
      else pass_cnt++;
      f_wr_en = 1'b1; f_data_in = 32'h01;
      step();
      f_data_in = 32'h02;
      step();
      f_wr_en = 1'b0; f_rd_en = 1'b1;
      step();
      f_rd_en = 1'b0;
      total_cnt++;
      if (f_data_valid !== 1'b1 || f_data_out !== 32'h02 || f_count !== 7'd1)
         $display("[TB] FAIL fwft_next: got valid %b data %h count %0d expected 1 02 1",
                  f_data_valid, f_data_out, f_count);
      else pass_cnt++;
   endtask

   // Asynchronous reset with ten words stored, then a clean write/read.
   task automatic test_reset_mid();
      for (int i = 0; i < 10; i++) begin
         wr_en = 1'b1; data_in = 32'h100 + 32'(i);
         step();
      end
      wr_en = 1'b0;
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      total_cnt++;
      if (count !== 7'd9 || data_out !== 32'h100)
         $display("[TB] FAIL rstmid_pre: got count %0d data %h expected 9 100", count, data_out);
      else pass_cnt++;
      #2;
      reset = 1'b1;
      #1;
      total_cnt++;
      if (count !== 7'd0 || fifo_empty !== 1'b1 || almost_empty !== 1'b1 || fifo_full !== 1'b0 ||
          data_valid !== 1'b0 || data_out !== 32'h0 || overflow !== 1'b0 || underflow !== 1'b0)
         $display("[TB] FAIL rstmid_async: got count %0d empty %b aempty %b full %b valid %b data %h expected 0 1 1 0 0 0",
                  count, fifo_empty, almost_empty, fifo_full, data_valid, data_out);
      else pass_cnt++;
      step();
      reset = 1'b0;
      step();
      wr_en = 1'b1; data_in = 32'h77;
      step();
      wr_en = 1'b0;
      total_cnt++;
      if (count !== 7'd1)
         $display("[TB] FAIL rstmid_write: got count %0d expected 1", count);
      else pass_cnt++;
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      total_cnt++;
      if (data_out !== 32'h77 || data_valid !== 1'b1 || fifo_empty !== 1'b1 || count !== 7'd0)
         $display("[TB] FAIL rstmid_read: got data %h valid %b empty %b count %0d expected 77 1 1 0",
                  data_out, data_valid, fifo_empty, count);
      else pass_cnt++;
   endtask

   // Sequencer: reset, run every scenario in order, print the summary.
   initial begin
      pass_cnt    = 0;
      total_cnt   = 0;
      reset       = 1'b1;
      wr_en       = 1'b0;
      rd_en       = 1'b0;
      clear_err   = 1'b0;
      data_in     = 32'h0;
      f_wr_en     = 1'b0;
      f_rd_en     = 1'b0;
      f_clear_err = 1'b0;
      f_data_in   = 32'h0;
      step();
      step();
      reset = 1'b0;
      step();
      $display("[TB] starting directed tests");
      test_reset();
      test_basic();
      test_full();
      test_back_to_back();
      test_wrap();
      test_fwft();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
